// File: rtl/seq_gen.sv
// Burst generator emitting N repetitions of the symbol pattern 1-2-3, with hold/freeze support.
// Define SEQ_GEN_GAP_EN to insert one idle GAP cycle between consecutive patterns of a burst.
module seq_gen (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] count,
  input  logic       hold,
  output logic [2:0] num,
  output logic       valid,
  output logic       busy,
  output logic       done,
  output logic [3:0] emitted
);

`ifdef SEQ_GEN_GAP_EN
  typedef enum logic [2:0] {IDLE, E1, E2, E3, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, E1, E2, E3} state_t;
`endif

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] emitted_q, emitted_d;
  logic       done_q, done_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    emitted_d = emitted_q;
    done_d    = 1'b0;
    if (!hold) begin
      case (state_q)
        IDLE: begin
          // done_q is high only in the first IDLE cycle after a burst; no restart there
          if (start && (count != 4'd0) && !done_q) begin
            cnt_d     = count;
            emitted_d = 4'd0;
            state_d   = E1;
          end
        end
        E1: state_d = E2;
        E2: state_d = E3;
        E3: begin
          emitted_d = emitted_q + 4'd1;
          if (emitted_q + 4'd1 < cnt_q) begin
`ifdef SEQ_GEN_GAP_EN
            state_d = GAP;
`else
            state_d = E1;
`endif
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
`ifdef SEQ_GEN_GAP_EN
        GAP: state_d = E1;
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      emitted_q <= 4'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      emitted_q <= emitted_d;
      done_q    <= done_d;
    end
  end

  // Symbol outputs follow the state directly; hold blanks them in the same cycle
  always_comb begin
    num = 3'd0;
    case (state_q)
      E1:      num = 3'd1;
      E2:      num = 3'd2;
      E3:      num = 3'd3;
      default: num = 3'd0;
    endcase
    if (hold) num = 3'd0;
  end

  assign valid   = (num != 3'd0);
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign emitted = emitted_q;

endmodule

// File: tb/tb_seq_gen.sv
// Scoreboard bench for seq_gen: per-cycle expected outputs are queued then compared on the falling edge.
module tb_seq_gen;
  logic       clk = 1'b0;
  logic       reset, start, hold;
  logic [3:0] count;
  logic [2:0] num;
  logic       valid, busy, done;
  logic [3:0] emitted;

  int checks = 0;
  int failures = 0;

`ifdef SEQ_GEN_GAP_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif

  // packed {num, valid, busy, done, emitted}
  logic [9:0] sb[$];

  seq_gen dut (
    .clk(clk), .reset(reset), .start(start), .count(count), .hold(hold),
    .num(num), .valid(valid), .busy(busy), .done(done), .emitted(emitted)
  );

  always #5 clk = ~clk;

  function automatic void push(int n, bit v, bit b, bit d, int e);
    logic [2:0] n3;
    logic [3:0] e4;
    n3 = n[2:0];
    e4 = e[3:0];
    sb.push_back({n3, v, b, d, e4});
  endfunction

  task automatic test_reset();
    logic [9:0] obs, exp_v;
    push(0, 0, 0, 0, 0);
    push(0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      reset = (i == 0); start = (i == 0); hold = (i == 0); count = 4'd5;
      @(posedge clk); @(negedge clk);
      obs = {num, valid, busy, done, emitted};
      checks++;
      if (sb.size() == 0) begin
        failures++; $display("FAIL reset c%0d: scoreboard empty", i);
      end else begin
        exp_v = sb.pop_front();
        if (obs !== exp_v) begin
          failures++; $display("FAIL reset c%0d: got %b want %b (num,valid,busy,done,emitted)", i, obs, exp_v);
        end
      end
    end
  endtask

  task automatic test_single();
    logic [9:0] obs, exp_v;
    push(1, 1, 1, 0, 0);
    push(2, 1, 1, 0, 0);
    push(3, 1, 1, 0, 0);
    push(0, 0, 0, 1, 1);
    push(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      start = (i == 0); count = 4'd1;
      @(posedge clk); @(negedge clk);
      obs = {num, valid, busy, done, emitted};
      checks++;
      if (sb.size() == 0) begin
        failures++; $display("FAIL single c%0d: scoreboard empty", i);
      end else begin
        exp_v = sb.pop_front();
        if (obs !== exp_v) begin
          failures++; $display("FAIL single c%0d: got %b want %b (num,valid,busy,done,emitted)", i, obs, exp_v);
        end
      end
    end
    start = 1'b0;
  endtask

  // count=3; start also pulsed while busy and in the done cycle, both must be ignored
  task automatic test_burst3();
    logic [9:0] obs, exp_v;
    int len;
    for (int p = 0; p < 3; p++) begin
      push(1, 1, 1, 0, p);
      push(2, 1, 1, 0, p);
      push(3, 1, 1, 0, p);
      if (GAP && p < 2) push(0, 0, 1, 0, p + 1);
    end
    push(0, 0, 0, 1, 3);
    push(0, 0, 0, 0, 3);
    len = sb.size();
    for (int i = 0; i < len; i++) begin
      start = (i <= 2) || (i == len - 1);
      count = (i == 0) ? 4'd3 : 4'd7;
      @(posedge clk); @(negedge clk);
      obs = {num, valid, busy, done, emitted};
      checks++;
      if (sb.size() == 0) begin
        failures++; $display("FAIL burst3 c%0d: scoreboard empty", i);
      end else begin
        exp_v = sb.pop_front();
        if (obs !== exp_v) begin
          failures++; $display("FAIL burst3 c%0d: got %b want %b (num,valid,busy,done,emitted)", i, obs, exp_v);
        end
      end
    end
    start = 1'b0;
  endtask

  // hold raised just after entering E2 and kept for 4 cycles
  task automatic test_hold();
    logic [9:0] obs, exp_v;
    int len;
    push(1, 1, 1, 0, 0);
    for (int k = 0; k < 4; k++) push(0, 0, 1, 0, 0);
    push(2, 1, 1, 0, 0);
    push(3, 1, 1, 0, 0);
    if (GAP) push(0, 0, 1, 0, 1);
    push(1, 1, 1, 0, 1);
    push(2, 1, 1, 0, 1);
    push(3, 1, 1, 0, 1);
    push(0, 0, 0, 1, 2);
    push(0, 0, 0, 0, 2);
    len = sb.size();
    start = 1'b1; count = 4'd2; hold = 1'b0;
    for (int i = 0; i < len; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      hold = (i >= 1 && i <= 4);
      @(negedge clk);
      obs = {num, valid, busy, done, emitted};
      checks++;
      if (sb.size() == 0) begin
        failures++; $display("FAIL hold c%0d: scoreboard empty", i);
      end else begin
        exp_v = sb.pop_front();
        if (obs !== exp_v) begin
          failures++; $display("FAIL hold c%0d: got %b want %b (num,valid,busy,done,emitted)", i, obs, exp_v);
        end
      end
    end
    hold = 1'b0;
  endtask

  // start with count=0, then start under hold in IDLE: both ignored
  task automatic test_ignore();
    logic [9:0] obs, exp_v;
    push(0, 0, 0, 0, 2);
    push(0, 0, 0, 0, 2);
    push(0, 0, 0, 0, 2);
    for (int i = 0; i < 3; i++) begin
      start = (i < 2);
      count = (i == 0) ? 4'd0 : 4'd4;
      hold  = (i == 1);
      @(posedge clk); @(negedge clk);
      obs = {num, valid, busy, done, emitted};
      checks++;
      if (sb.size() == 0) begin
        failures++; $display("FAIL ignore c%0d: scoreboard empty", i);
      end else begin
        exp_v = sb.pop_front();
        if (obs !== exp_v) begin
          failures++; $display("FAIL ignore c%0d: got %b want %b (num,valid,busy,done,emitted)", i, obs, exp_v);
        end
      end
    end
    start = 1'b0; hold = 1'b0;
  endtask

  task automatic test_reset_abort();
    logic [9:0] obs, exp_v;
    push(1, 1, 1, 0, 0);
    push(2, 1, 1, 0, 0);
    push(0, 0, 0, 0, 0);
    push(0, 0, 0, 0, 0);
    push(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      start = (i == 0); count = 4'd3;
      reset = (i == 2);
      @(posedge clk); @(negedge clk);
      obs = {num, valid, busy, done, emitted};
      checks++;
      if (sb.size() == 0) begin
        failures++; $display("FAIL abort c%0d: scoreboard empty", i);
      end else begin
        exp_v = sb.pop_front();
        if (obs !== exp_v) begin
          failures++; $display("FAIL abort c%0d: got %b want %b (num,valid,busy,done,emitted)", i, obs, exp_v);
        end
      end
    end
    reset = 1'b0; start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; hold = 1'b0; count = 4'd0;
    @(negedge clk);
    test_reset();
    test_single();
    test_burst3();
    test_hold();
    test_ignore();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
